// File: rtl/key_pkg.sv
// Shared definitions for the UART keyboard front end: event codes,
// decoder FSM states, ASCII constants and the byte-to-event decode helpers.
package key_pkg;

  typedef enum logic [2:0] {
    EV_UP    = 3'd0,
    EV_DOWN  = 3'd1,
    EV_LEFT  = 3'd2,
    EV_RIGHT = 3'd3,
    EV_ENTER = 3'd4,
    EV_SPACE = 3'd5,
    EV_ESC   = 3'd6
  } key_event_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GOT_ESC = 2'd1,
    ST_GOT_CSI = 2'd2
  } key_state_e;

  localparam logic [7:0] ASCII_W_LO     = 8'h77;
  localparam logic [7:0] ASCII_S_LO     = 8'h73;
  localparam logic [7:0] ASCII_A_LO     = 8'h61;
  localparam logic [7:0] ASCII_D_LO     = 8'h64;
  localparam logic [7:0] ASCII_W_UP     = 8'h57;
  localparam logic [7:0] ASCII_S_UP     = 8'h53;
  localparam logic [7:0] ASCII_A_UP     = 8'h41;
  localparam logic [7:0] ASCII_D_UP     = 8'h44;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
  localparam logic [7:0] ASCII_ARROW_A  = 8'h41;
  localparam logic [7:0] ASCII_ARROW_B  = 8'h42;
  localparam logic [7:0] ASCII_ARROW_C  = 8'h43;
  localparam logic [7:0] ASCII_ARROW_D  = 8'h44;

  typedef struct packed {
    logic       hit;
    key_event_e code;
  } key_decode_t;

  // Single-byte keys seen in IDLE; uppercase WASD only hits when ci is set.
  function automatic key_decode_t decode_plain(input logic [7:0] b, input logic ci);
    key_decode_t r;
    r.hit  = 1'b1;
    r.code = EV_UP;
    case (b)
      ASCII_W_LO:  r.code = EV_UP;
      ASCII_S_LO:  r.code = EV_DOWN;
      ASCII_A_LO:  r.code = EV_LEFT;
      ASCII_D_LO:  r.code = EV_RIGHT;
      ASCII_SPACE: r.code = EV_SPACE;
      ASCII_CR:    r.code = EV_ENTER;
      ASCII_W_UP: begin
        r.code = EV_UP;
        r.hit  = ci;
      end
      ASCII_S_UP: begin
        r.code = EV_DOWN;
        r.hit  = ci;
      end
      ASCII_A_UP: begin
        r.code = EV_LEFT;
        r.hit  = ci;
      end
      ASCII_D_UP: begin
        r.code = EV_RIGHT;
        r.hit  = ci;
      end
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

  // Final byte of an ESC [ x arrow sequence.
  function automatic key_decode_t decode_arrow(input logic [7:0] b);
    key_decode_t r;
    r.hit  = 1'b1;
    r.code = EV_UP;
    case (b)
      ASCII_ARROW_A: r.code = EV_UP;
      ASCII_ARROW_B: r.code = EV_DOWN;
      ASCII_ARROW_C: r.code = EV_RIGHT;
      ASCII_ARROW_D: r.code = EV_LEFT;
      default:       r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with combinational head read,
// occupancy count and a one-cycle drop flag for pushes refused while full.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop frees the slot the same cycle, so a full FIFO can still take a push
  // when it is also being popped; an empty FIFO never bypasses.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// UART keyboard front end: edge-detects incoming bytes, decodes WASD/Enter/
// Space and ANSI arrow/ESC sequences with a lone-ESC timeout, and queues events.
module key_event_queue
  import key_pkg::*;
#(
  parameter int DEPTH            = 4,
  parameter int ESC_TIMEOUT      = 50000,
  parameter int CASE_INSENSITIVE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             uart_data,
  input  logic                   uart_valid,
  output logic [2:0]             key_code,
  output logic                   key_valid,
  input  logic                   key_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam int TW = $clog2(ESC_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ESC_TIMEOUT - 1);

  logic          uart_valid_q;
  key_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          overflow_q, overflow_d;

  logic          byte_accept;
  logic          timeout;
  logic          push_valid;
  key_event_e    push_code;
  key_decode_t   plain_dec, arrow_dec;

  logic          fifo_empty, fifo_full, fifo_drop, fifo_pop;

  assign byte_accept = uart_valid && !uart_valid_q;
  assign timeout     = (state_q != ST_IDLE) && (timer_q == TIMER_LAST);
  assign plain_dec   = decode_plain(uart_data, CASE_INSENSITIVE != 0);
  assign arrow_dec   = decode_arrow(uart_data);

  // A byte arriving on the timeout edge takes precedence, hence byte_accept
  // is tested before timeout in every state.
  always_comb begin
    state_d    = state_q;
    push_valid = 1'b0;
    push_code  = EV_ESC;
    case (state_q)
      ST_IDLE: begin
        if (byte_accept) begin
          if (uart_data == ASCII_ESC) begin
            state_d = ST_GOT_ESC;
          end else begin
            push_valid = plain_dec.hit;
            push_code  = plain_dec.code;
          end
        end
      end
      ST_GOT_ESC: begin
        if (byte_accept) begin
          if (uart_data == ASCII_LBRACKET) begin
            state_d = ST_GOT_CSI;
          end else begin
            push_valid = 1'b1;
            push_code  = EV_ESC;
            if (uart_data != ASCII_ESC) begin
              state_d = ST_IDLE;
            end
          end
        end else if (timeout) begin
          push_valid = 1'b1;
          push_code  = EV_ESC;
          state_d    = ST_IDLE;
        end
      end
      ST_GOT_CSI: begin
        if (byte_accept) begin
          push_valid = arrow_dec.hit;
          push_code  = arrow_dec.code;
          state_d    = ST_IDLE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer counts cycles since the last byte while a sequence is pending.
  always_comb begin
    timer_d = timer_q + TW'(1);
    if (byte_accept || (state_q == ST_IDLE) || timeout) begin
      timer_d = '0;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_valid_q <= 1'b0;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      uart_valid_q <= uart_valid;
      state_q      <= state_d;
      timer_q      <= timer_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fifo_pop  = !fifo_empty && key_ready;
  assign key_valid = !fifo_empty;
  assign overflow  = overflow_q;

  key_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_valid),
    .push_data (push_code),
    .pop       (fifo_pop),
    .pop_data  (key_code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

endmodule
